// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and arbiter state encoding.
package sdram_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM arbiter: hands the command bus to init, refresh, write or read.
// Refresh has priority; write/read ties alternate using last_wr.
module sdram_arbit
   import sdram_pkg::*;
(
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic        flag_init_end,
   input  logic [3:0]  init_cmd,
   input  logic [11:0] init_addr,
   input  logic        ref_req,
   input  logic        flag_ref_end,
   input  logic [3:0]  aref_cmd,
   input  logic [11:0] ref_addr,
   output logic        ref_en,
   input  logic        wr_req,
   input  logic        flag_wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [11:0] wr_addr,
   input  logic [1:0]  wr_bank,
   output logic        wr_en,
   input  logic        rd_req,
   input  logic        flag_rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [11:0] rd_addr,
   input  logic [1:0]  rd_bank,
   output logic        rd_en,
   output logic        sdram_cke,
   output logic        sdram_cs_n,
   output logic        sdram_ras_n,
   output logic        sdram_cas_n,
   output logic        sdram_we_n,
   output logic [1:0]  sdram_bank,
   output logic [11:0] sdram_addr
);

   arb_state_t  state, next_state;
   logic        last_wr;
   logic [3:0]  cmd;

   // State register.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Next-state: requests are only looked at in ARBIT, so every grant is
   // separated by at least one ARBIT cycle.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (flag_init_end) next_state = ST_ARBIT;
         ST_ARBIT: begin
            if (ref_req)                next_state = ST_AREF;
            else if (wr_req && rd_req)  next_state = last_wr ? ST_READ : ST_WRITE;
            else if (wr_req)            next_state = ST_WRITE;
            else if (rd_req)            next_state = ST_READ;
         end
         ST_AREF:  if (flag_ref_end) next_state = ST_ARBIT;
         ST_WRITE: if (flag_wr_end)  next_state = ST_ARBIT;
         ST_READ:  if (flag_rd_end)  next_state = ST_ARBIT;
         default:  next_state = ST_IDLE;
      endcase
   end

   // One-cycle grant pulses on the ARBIT->X edge, and tie-break history.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         ref_en  <= 1'b0;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         last_wr <= 1'b0;
      end else begin
         ref_en <= (state == ST_ARBIT) && (next_state == ST_AREF);
         wr_en  <= (state == ST_ARBIT) && (next_state == ST_WRITE);
         rd_en  <= (state == ST_ARBIT) && (next_state == ST_READ);
         if (state == ST_ARBIT && next_state == ST_WRITE)     last_wr <= 1'b1;
         else if (state == ST_ARBIT && next_state == ST_READ) last_wr <= 1'b0;
      end
   end

   // Clock enable rises on the first clock after reset release.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) sdram_cke <= 1'b0;
      else          sdram_cke <= 1'b1;
   end

   // Command/address mux driven by the current owner of the bus.
   always_comb begin
      cmd        = CMD_NOP;
      sdram_addr = '0;
      sdram_bank = '0;
      case (state)
         ST_IDLE:  begin cmd = init_cmd; sdram_addr = init_addr; end
         ST_AREF:  begin cmd = aref_cmd; sdram_addr = ref_addr;  end
         ST_WRITE: begin cmd = wr_cmd;   sdram_addr = wr_addr; sdram_bank = wr_bank; end
         ST_READ:  begin cmd = rd_cmd;   sdram_addr = rd_addr; sdram_bank = rd_bank; end
         default:  ;
      endcase
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: expected grant order is queued when
// requests are raised and compared as grant pulses appear.
module tb_sdram_arbit;

   logic        sclk, s_rst_n, flag_init_end;
   logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
   logic [11:0] init_addr, ref_addr, wr_addr, rd_addr;
   logic [1:0]  wr_bank, rd_bank;
   logic        ref_req, flag_ref_end, ref_en;
   logic        wr_req, flag_wr_end, wr_en;
   logic        rd_req, flag_rd_end, rd_en;
   logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_bank;
   logic [11:0] sdram_addr;
   logic [17:0] pins;

   localparam logic [2:0] G_F = 3'b100;
   localparam logic [2:0] G_W = 3'b010;
   localparam logic [2:0] G_R = 3'b001;

   int checks_total  = 0;
   int checks_passed = 0;
   logic [2:0] exp_q[$];

   sdram_arbit dut (
      .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
      .init_cmd(init_cmd), .init_addr(init_addr),
      .ref_req(ref_req), .flag_ref_end(flag_ref_end), .aref_cmd(aref_cmd),
      .ref_addr(ref_addr), .ref_en(ref_en),
      .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd),
      .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_en(wr_en),
      .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd),
      .rd_addr(rd_addr), .rd_bank(rd_bank), .rd_en(rd_en),
      .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
      .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
   );

   assign pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr};

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Expected pin pattern: 0 idle, 1 arbit, 2 aref, 3 write, 4 read.
   function automatic logic [17:0] pins_for(input int k);
      case (k)
         0:       return {4'b0010, 2'b00, 12'h400};
         1:       return {4'b0111, 2'b00, 12'h000};
         2:       return {4'b0001, 2'b00, 12'h0A5};
         3:       return {4'b0100, 2'b01, 12'h123};
         4:       return {4'b0101, 2'b10, 12'h456};
         default: return '0;
      endcase
   endfunction

   function automatic int kind_idx(input logic [2:0] kind);
      if (kind == G_F) return 2;
      if (kind == G_W) return 3;
      return 4;
   endfunction

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   // Grant monitor: every pulse must match the head of the scoreboard.
   always @(posedge sclk) begin
      #2;
      if (ref_en || wr_en || rd_en) begin
         if (exp_q.size() == 0)
            check("spurious_grant", 32'({ref_en, wr_en, rd_en}), 32'd0);
         else
            check("grant_order", 32'({ref_en, wr_en, rd_en}), 32'(exp_q.pop_front()));
      end
   end

   // Wait (bounded) for a grant, check latency/pins/pulse width, then end the op.
   task automatic run_op(input logic [2:0] kind, input int exp_wait, input bit drop);
      int  waited;
      bit  got;
      waited = 0;
      got    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         waited++;
         if (ref_en || wr_en || rd_en) begin
            got = 1'b1;
            break;
         end
      end
      check("grant_seen", 32'(got), 32'd1);
      if (!got) return;
      check("grant_latency", 32'(waited), 32'(exp_wait));
      check("grant_pins", 32'(pins), 32'(pins_for(kind_idx(kind))));
      if (drop) begin
         if (kind == G_F) ref_req = 1'b0;
         if (kind == G_W) wr_req  = 1'b0;
         if (kind == G_R) rd_req  = 1'b0;
      end
      step();
      check("pulse_width", 32'({ref_en, wr_en, rd_en}), 32'd0);
      check("busy_pins", 32'(pins), 32'(pins_for(kind_idx(kind))));
      if (kind == G_F) flag_ref_end = 1'b1;
      if (kind == G_W) flag_wr_end  = 1'b1;
      if (kind == G_R) flag_rd_end  = 1'b1;
      step();
      flag_ref_end = 1'b0;
      flag_wr_end  = 1'b0;
      flag_rd_end  = 1'b0;
      check("back_to_arbit", 32'(pins), 32'(pins_for(1)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      init_cmd = 4'b0010; init_addr = 12'h400;
      aref_cmd = 4'b0001; ref_addr  = 12'h0A5;
      wr_cmd   = 4'b0100; wr_addr   = 12'h123; wr_bank = 2'b01;
      rd_cmd   = 4'b0101; rd_addr   = 12'h456; rd_bank = 2'b10;
      flag_init_end = 1'b0; ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
      s_rst_n = 1'b1;
      #1 s_rst_n = 1'b0;
      #2;
      check("rst_cke", 32'(sdram_cke), 32'd0);
      check("rst_grants", 32'({ref_en, wr_en, rd_en}), 32'd0);
      check("rst_pins", 32'(pins), 32'(pins_for(0)));
      step();
      step();
      check("rst_cke_held", 32'(sdram_cke), 32'd0);
      s_rst_n = 1'b1;
      step();
      check("cke_after_release", 32'(sdram_cke), 32'd1);

      // Idle holds until init completes.
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle_pins", 32'(pins), 32'(pins_for(0)));
      end
      flag_init_end = 1'b1;
      step();
      check("init_handoff_nop", 32'(pins), 32'(pins_for(1)));
      check("init_handoff_nogrant", 32'({ref_en, wr_en, rd_en}), 32'd0);

      // All three requests at once: refresh, then write (first tie), then read.
      ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      exp_q.push_back(G_F); exp_q.push_back(G_W); exp_q.push_back(G_R);
      run_op(G_F, 1, 1'b1);
      run_op(G_W, 1, 1'b1);
      run_op(G_R, 1, 1'b1);

      // Continuous write and read: alternate with one ARBIT cycle between.
      wr_req = 1'b1; rd_req = 1'b1;
      exp_q.push_back(G_W); exp_q.push_back(G_R);
      exp_q.push_back(G_W); exp_q.push_back(G_R);
      run_op(G_W, 1, 1'b0);
      run_op(G_R, 1, 1'b0);
      run_op(G_W, 1, 1'b0);
      run_op(G_R, 1, 1'b0);
      wr_req = 1'b0; rd_req = 1'b0;

      // Refresh raised mid-write waits for the write to end.
      wr_req = 1'b1;
      exp_q.push_back(G_W);
      step();
      check("w_grant", 32'(wr_en), 32'd1);
      wr_req  = 1'b0;
      ref_req = 1'b1;
      exp_q.push_back(G_F);
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_preempt", 32'(ref_en), 32'd0);
         check("no_preempt_pins", 32'(pins), 32'(pins_for(3)));
      end
      flag_wr_end = 1'b1;
      step();
      flag_wr_end = 1'b0;
      check("ref_wait_arbit", 32'(ref_en), 32'd0);
      check("ref_wait_pins", 32'(pins), 32'(pins_for(1)));
      step();
      check("ref_after_write", 32'(ref_en), 32'd1);
      ref_req = 1'b0;
      step();
      flag_ref_end = 1'b1;
      step();
      flag_ref_end = 1'b0;

      // Reset during a read aborts straight to idle.
      rd_req = 1'b1;
      exp_q.push_back(G_R);
      step();
      check("r_grant", 32'(rd_en), 32'd1);
      rd_req = 1'b0;
      step();
      check("r_busy_pins", 32'(pins), 32'(pins_for(4)));
      s_rst_n = 1'b0;
      flag_init_end = 1'b0;
      #1;
      check("abort_pins", 32'(pins), 32'(pins_for(0)));
      check("abort_rd_en", 32'(rd_en), 32'd0);
      check("abort_cke", 32'(sdram_cke), 32'd0);
      step();
      s_rst_n = 1'b1;
      wr_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_idle", 32'(pins), 32'(pins_for(0)));
         check("post_rst_nogrant", 32'({ref_en, wr_en, rd_en}), 32'd0);
      end
      exp_q.push_back(G_W);
      flag_init_end = 1'b1;
      step();
      check("post_rst_arbit", 32'(pins), 32'(pins_for(1)));
      check("post_rst_wait", 32'(wr_en), 32'd0);
      step();
      check("post_rst_grant", 32'(wr_en), 32'd1);
      wr_req = 1'b0;
      step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
